// File: rtl/co2_sensor_pkg.sv
// Shared types and constants for the CO2 sensor front-end: reader FSM states,
// frame geometry and the inverted-byte checksum test.
package co2_sensor_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CHECK
  } reader_state_t;

  function automatic logic frame_good(input logic [DATA_BITS-1:0] d,
                                      input logic [DATA_BITS-1:0] c);
    return c == ~d;
  endfunction

endpackage

// File: rtl/co2_serial_shifter.sv
// SCLK generator and MSB-first shift-in register. A start pulse launches 16
// SCLK periods (low phase first); done flags the cycle before SCLK's final fall.
module co2_serial_shifter
  import co2_sensor_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             phase_end;

  assign phase_end = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done      = phase_end && sclk && (bit_cnt == BIT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (abort) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (busy) begin
      if (phase_end) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (done) busy <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // miso is captured on the same edge that drives SCLK high
  always_ff @(posedge clk) begin
    if (phase_end && !sclk && !abort)
      frame <= {frame[FRAME_BITS-2:0], miso};
  end

endmodule

// File: rtl/co2_sensor_reader.sv
// CO2 sensor reader: periodic frame FSM, drift-free period counter,
// checksum validation, 2^AVG_LOG2 averaging and consecutive-bad-frame fault.
module co2_sensor_reader
  import co2_sensor_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int FAULT_LIMIT   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 sensor_miso,
  output logic                 sensor_cs_n,
  output logic                 sensor_sclk,
  output logic [DATA_BITS-1:0] CO2_level,
  output logic                 level_valid,
  output logic                 sensor_fault
);

  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int ACC_W = DATA_BITS + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int BAD_W = $clog2(FAULT_LIMIT + 1);

  reader_state_t          state, next_state;
  logic [PH_W-1:0]        phase;
  logic [PER_W-1:0]       period;
  logic [ACC_W-1:0]       acc;
  logic [SMP_W-1:0]       smp_cnt;
  logic [BAD_W-1:0]       bad_cnt;
  logic                   start, abort, shift_done, cs_n_d;
  logic [FRAME_BITS-1:0]  frame;
  logic [DATA_BITS-1:0]   frame_d, frame_c;
  logic [ACC_W-1:0]       acc_sum;

  function automatic logic [BAD_W-1:0] sat_inc(input logic [BAD_W-1:0] v);
    return (v == BAD_W'(FAULT_LIMIT)) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    return DATA_BITS'(s >> AVG_LOG2);
  endfunction

  assign frame_d = frame[FRAME_BITS-1 -: DATA_BITS];
  assign frame_c = frame[DATA_BITS-1:0];
  assign acc_sum = acc + ACC_W'(frame_d);

  co2_serial_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .miso    (sensor_miso),
    .sclk    (sensor_sclk),
    .done    (shift_done),
    .frame   (frame)
  );

  always_comb begin
    next_state = state;
    start      = 1'b0;
    abort      = 1'b0;
    cs_n_d     = 1'b1;
    unique case (state)
      IDLE:     if (enable) next_state = CS_SETUP;
      WAIT: begin
        if (!enable) next_state = IDLE;
        else if (period == PER_W'(SAMPLE_PERIOD - 1)) next_state = CS_SETUP;
      end
      CS_SETUP: begin
        if (!enable) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (phase == PH_W'(CLK_DIV - 1)) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (!enable) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (shift_done) begin
          next_state = CS_HOLD;
        end
      end
      CS_HOLD: begin
        if (!enable) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (phase == PH_W'(CLK_DIV)) begin
          next_state = CHECK;
        end
      end
      CHECK: begin
        // at the minimum period the next frame starts straight from CHECK
        if (enable && period == PER_W'(SAMPLE_PERIOD - 1)) next_state = CS_SETUP;
        else next_state = WAIT;
      end
      default:  next_state = IDLE;
    endcase
    // CS_HOLD keeps cs_n low for CLK_DIV cycles, then one cycle high before CHECK
    unique case (next_state)
      CS_SETUP, SHIFT: cs_n_d = 1'b0;
      CS_HOLD:         cs_n_d = (state == CS_HOLD) && (phase >= PH_W'(CLK_DIV - 1));
      default:         cs_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= '0;
      period      <= '0;
      sensor_cs_n <= 1'b1;
    end else begin
      state       <= next_state;
      sensor_cs_n <= cs_n_d;
      phase       <= (next_state != state) ? '0 : phase + 1'b1;
      period      <= (next_state == CS_SETUP && state != CS_SETUP) ? '0 : period + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc          <= '0;
      smp_cnt      <= '0;
      bad_cnt      <= '0;
      CO2_level    <= '0;
      level_valid  <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (state == CHECK) begin
        if (frame_good(frame_d, frame_c)) begin
          bad_cnt      <= '0;
          sensor_fault <= 1'b0;
          if (smp_cnt == SMP_W'((1 << AVG_LOG2) - 1)) begin
            CO2_level   <= avg_trunc(acc_sum);
            level_valid <= 1'b1;
            acc         <= '0;
            smp_cnt     <= '0;
          end else begin
            acc     <= acc_sum;
            smp_cnt <= smp_cnt + 1'b1;
          end
        end else begin
          bad_cnt <= sat_inc(bad_cnt);
          if (sat_inc(bad_cnt) == BAD_W'(FAULT_LIMIT)) sensor_fault <= 1'b1;
        end
      end
    end
  end

endmodule
